// File: rtl/dll_phy_code_tracker_if.sv
// Control and status bundle of the multi-channel DLL code tracker.
// The master drives calibration control and phase-detector samples; the slave returns codes and status.
interface dll_phy_code_tracker_if #(
  parameter int NumCh = 4,
  parameter int CodeW = 8
);
  logic                   cal_en_i;
  logic                   cal_start_i;
  logic [NumCh-1:0]       pd_valid_i;
  logic [NumCh-1:0]       pd_late_i;
  logic [NumCh*CodeW-1:0] code_o;
  logic [NumCh-1:0]       code_upd_o;
  logic [NumCh-1:0]       locked_o;
  logic [NumCh-1:0]       err_o;
  logic                   busy_o;

  modport master (
    output cal_en_i, cal_start_i, pd_valid_i, pd_late_i,
    input  code_o, code_upd_o, locked_o, err_o, busy_o
  );

  modport slave (
    input  cal_en_i, cal_start_i, pd_valid_i, pd_late_i,
    output code_o, code_upd_o, locked_o, err_o, busy_o
  );
endinterface

// File: rtl/dll_phy_code_tracker.sv
// Multi-channel DLL delay-code tracker: each channel votes on early/late samples,
// steps its code after a settle window, declares lock on reversals and flags saturation.
module dll_phy_code_tracker #(
  parameter int NumCh         = 4,
  parameter int CodeW         = 8,
  parameter int InitCode      = 128,
  parameter int SettleCycles  = 8,
  parameter int FilterDepth   = 4,
  parameter int LockReversals = 3,
  parameter int LockLossSteps = 4
) (
  input logic                   clk_i,
  input logic                   rst_i,
  dll_phy_code_tracker_if.slave cal_bus
);

  localparam int AccW  = $clog2(FilterDepth) + 2;
  localparam int SetW  = $clog2(SettleCycles + 1);
  localparam int RevW  = $clog2(LockReversals + 1);
  localparam int SameW = $clog2(LockLossSteps + 1);

  localparam logic signed [AccW-1:0] AccPos   = AccW'(FilterDepth);
  localparam logic signed [AccW-1:0] AccNeg   = AccW'(-FilterDepth);
  localparam logic signed [AccW-1:0] AccOne   = AccW'(1);
  localparam logic [SetW-1:0]        SetLast  = SetW'(SettleCycles - 1);
  localparam logic [SetW-1:0]        SetOne   = SetW'(1);
  localparam logic [RevW-1:0]        RevMax   = RevW'(LockReversals);
  localparam logic [RevW-1:0]        RevOne   = RevW'(1);
  localparam logic [SameW-1:0]       SameMax  = SameW'(LockLossSteps);
  localparam logic [SameW-1:0]       SameOne  = SameW'(1);
  localparam logic [CodeW-1:0]       CodeInit = CodeW'(InitCode);
  localparam logic [CodeW-1:0]       CodeMax  = {CodeW{1'b1}};
  localparam logic [CodeW-1:0]       CodeZero = {CodeW{1'b0}};
  localparam logic [CodeW-1:0]       CodeOne  = CodeW'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    ERR    = 2'd3
  } state_t;

  state_t                  state_q    [NumCh];
  state_t                  state_d    [NumCh];
  logic [SetW-1:0]         set_cnt_q  [NumCh];
  logic [SetW-1:0]         set_cnt_d  [NumCh];
  logic signed [AccW-1:0]  acc_q      [NumCh];
  logic signed [AccW-1:0]  acc_d      [NumCh];
  logic signed [AccW-1:0]  acc_sum    [NumCh];
  logic [RevW-1:0]         rev_q      [NumCh];
  logic [RevW-1:0]         rev_d      [NumCh];
  logic [RevW-1:0]         rev_nxt    [NumCh];
  logic [SameW-1:0]        same_q     [NumCh];
  logic [SameW-1:0]        same_d     [NumCh];
  logic [SameW-1:0]        same_nxt   [NumCh];
  logic                    last_up_q  [NumCh];
  logic                    last_up_d  [NumCh];
  logic                    have_dir_q [NumCh];
  logic                    have_dir_d [NumCh];
  logic                    step_hit   [NumCh];
  logic                    step_up    [NumCh];
  logic [CodeW-1:0]        code_q     [NumCh];
  logic [CodeW-1:0]        code_d     [NumCh];
  logic                    upd_q      [NumCh];
  logic                    upd_d      [NumCh];
  logic                    locked_q   [NumCh];
  logic                    locked_d   [NumCh];
  logic                    err_q      [NumCh];
  logic                    err_d      [NumCh];
  logic                    busy_q;
  logic                    busy_d;

  function automatic logic [RevW-1:0] sat_rev(input logic [RevW-1:0] v);
    if (v == RevMax) begin
      return v;
    end else begin
      return v + RevOne;
    end
  endfunction

  function automatic logic [SameW-1:0] sat_same(input logic [SameW-1:0] v);
    if (v == SameMax) begin
      return v;
    end else begin
      return v + SameOne;
    end
  endfunction

  // State and output registers for every channel
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int n = 0; n < NumCh; n++) begin
        state_q[n]    <= IDLE;
        set_cnt_q[n]  <= '0;
        acc_q[n]      <= '0;
        rev_q[n]      <= '0;
        same_q[n]     <= '0;
        last_up_q[n]  <= 1'b0;
        have_dir_q[n] <= 1'b0;
        code_q[n]     <= CodeInit;
        upd_q[n]      <= 1'b0;
        locked_q[n]   <= 1'b0;
        err_q[n]      <= 1'b0;
      end
      busy_q <= 1'b0;
    end else begin
      for (int n = 0; n < NumCh; n++) begin
        state_q[n]    <= state_d[n];
        set_cnt_q[n]  <= set_cnt_d[n];
        acc_q[n]      <= acc_d[n];
        rev_q[n]      <= rev_d[n];
        same_q[n]     <= same_d[n];
        last_up_q[n]  <= last_up_d[n];
        have_dir_q[n] <= have_dir_d[n];
        code_q[n]     <= code_d[n];
        upd_q[n]      <= upd_d[n];
        locked_q[n]   <= locked_d[n];
        err_q[n]      <= err_d[n];
      end
      busy_q <= busy_d;
    end
  end

  // Per-channel next state: disable beats start, start beats a threshold step
  always_comb begin
    busy_d = 1'b0;
    for (int n = 0; n < NumCh; n++) begin
      state_d[n]    = state_q[n];
      set_cnt_d[n]  = set_cnt_q[n];
      acc_d[n]      = acc_q[n];
      rev_d[n]      = rev_q[n];
      same_d[n]     = same_q[n];
      last_up_d[n]  = last_up_q[n];
      have_dir_d[n] = have_dir_q[n];
      code_d[n]     = code_q[n];
      upd_d[n]      = 1'b0;
      locked_d[n]   = locked_q[n];
      err_d[n]      = err_q[n];
      acc_sum[n]    = cal_bus.pd_late_i[n] ? (acc_q[n] - AccOne) : (acc_q[n] + AccOne);
      // Only an early vote can reach +FilterDepth, so the step goes up exactly when not late
      step_up[n]    = ~cal_bus.pd_late_i[n];
      step_hit[n]   = (state_q[n] == SAMPLE) && cal_bus.pd_valid_i[n] &&
                      ((acc_sum[n] == AccPos) || (acc_sum[n] == AccNeg));
      rev_nxt[n]    = sat_rev(rev_q[n]);
      same_nxt[n]   = sat_same(same_q[n]);

      if (!cal_bus.cal_en_i) begin
        state_d[n]   = IDLE;
        set_cnt_d[n] = '0;
        acc_d[n]     = '0;
        locked_d[n]  = 1'b0;
      end else if (cal_bus.cal_start_i) begin
        state_d[n]    = SETTLE;
        set_cnt_d[n]  = '0;
        acc_d[n]      = '0;
        rev_d[n]      = '0;
        same_d[n]     = '0;
        last_up_d[n]  = 1'b0;
        have_dir_d[n] = 1'b0;
        code_d[n]     = CodeInit;
        upd_d[n]      = 1'b1;
        locked_d[n]   = 1'b0;
        err_d[n]      = 1'b0;
      end else begin
        case (state_q[n])
          SETTLE: begin
            if (set_cnt_q[n] == SetLast) begin
              state_d[n]   = SAMPLE;
              set_cnt_d[n] = '0;
            end else begin
              set_cnt_d[n] = set_cnt_q[n] + SetOne;
            end
          end
          SAMPLE: begin
            if (step_hit[n]) begin
              acc_d[n] = '0;
              if (step_up[n] ? (code_q[n] != CodeMax) : (code_q[n] != CodeZero)) begin
                code_d[n]     = step_up[n] ? (code_q[n] + CodeOne) : (code_q[n] - CodeOne);
                upd_d[n]      = 1'b1;
                state_d[n]    = SETTLE;
                set_cnt_d[n]  = '0;
                last_up_d[n]  = step_up[n];
                have_dir_d[n] = 1'b1;
                if (!have_dir_q[n]) begin
                  same_d[n] = SameOne;
                end else if (step_up[n] != last_up_q[n]) begin
                  rev_d[n]  = rev_nxt[n];
                  same_d[n] = SameOne;
                  if (rev_nxt[n] == RevMax) begin
                    locked_d[n] = 1'b1;
                  end else begin
                    locked_d[n] = locked_q[n];
                  end
                end else begin
                  same_d[n] = same_nxt[n];
                  // A run of same-direction steps means the loop drifted away from the edge
                  if (locked_q[n] && (same_nxt[n] == SameMax)) begin
                    locked_d[n] = 1'b0;
                    rev_d[n]    = '0;
                  end else begin
                    locked_d[n] = locked_q[n];
                  end
                end
              end else begin
                err_d[n]    = 1'b1;
                locked_d[n] = 1'b0;
                state_d[n]  = ERR;
              end
            end else if (cal_bus.pd_valid_i[n]) begin
              acc_d[n] = acc_sum[n];
            end else begin
              acc_d[n] = acc_q[n];
            end
          end
          default: begin
            state_d[n] = state_q[n];
          end
        endcase
      end

      busy_d = busy_d | (state_d[n] == SETTLE) | (state_d[n] == SAMPLE);
    end
  end

  // Pack registered per-channel state onto the bus
  always_comb begin
    cal_bus.code_o     = '0;
    cal_bus.code_upd_o = '0;
    cal_bus.locked_o   = '0;
    cal_bus.err_o      = '0;
    for (int n = 0; n < NumCh; n++) begin
      cal_bus.code_o[n*CodeW +: CodeW] = code_q[n];
      cal_bus.code_upd_o[n]            = upd_q[n];
      cal_bus.locked_o[n]              = locked_q[n];
      cal_bus.err_o[n]                 = err_q[n];
    end
    cal_bus.busy_o = busy_q;
  end

endmodule
